// File: rtl/id_ex_skid_reg_pkg.sv
// Shared decode/execute pipeline types: ctrl bundle layout, ALU codes, bubble constant, FSM states.
// Latency: none (types and constants only).
// Backpressure: n/a. Optional feature macro used by the register: ID_EX_PERF_EN.
package id_ex_skid_reg_pkg;

   localparam int XLEN_DEF       = 32;
   localparam int REG_ADDR_W_DEF = 5;
   localparam int CTRL_W         = 10;

   // ALU decoder output encodings (100, 110, 111 are unused by the decoder)
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   // MSB-first: {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic [2:0] alu_control;
      logic       alu_src;
   } ctrl_t;

   // Bit offsets of each field inside the flat 10-bit ctrl vector
   localparam int CTRL_ALU_SRC_B     = 0;
   localparam int CTRL_ALU_CTL_LSB   = 1;
   localparam int CTRL_BRANCH_B      = 4;
   localparam int CTRL_JUMP_B        = 5;
   localparam int CTRL_MEM_WRITE_B   = 6;
   localparam int CTRL_RESULT_SRC_LSB = 7;
   localparam int CTRL_REG_WRITE_B   = 9;

   // Bubble: no architectural side effects if execute ignores m_valid
   localparam ctrl_t CTRL_NOP = '0;

   // Occupancy encoded as {main_v, skid_v}; 01 is unreachable
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } skid_state_e;

   // Saturating increment for the performance counters
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/id_ex_skid_reg_if.sv
// Decode-to-execute handshake bundle: decode payload in, execute payload out, flush.
// Latency: none (wires only).
// Backpressure: s_ready toward decode, m_ready from execute; slave = the pipeline register, master = its environment.
interface id_ex_skid_reg_if #(
   parameter int XLEN       = id_ex_skid_reg_pkg::XLEN_DEF,
   parameter int REG_ADDR_W = id_ex_skid_reg_pkg::REG_ADDR_W_DEF
);
   import id_ex_skid_reg_pkg::*;

   // decode side
   logic                  s_valid;
   logic                  s_ready;
   ctrl_t                 id_ctrl_i;
   logic [XLEN-1:0]       id_rd1_i;
   logic [XLEN-1:0]       id_rd2_i;
   logic [XLEN-1:0]       id_imm_i;
   logic [XLEN-1:0]       id_pc_i;
   logic [XLEN-1:0]       id_pcplus4_i;
   logic [REG_ADDR_W-1:0] id_rs1_i;
   logic [REG_ADDR_W-1:0] id_rs2_i;
   logic [REG_ADDR_W-1:0] id_rd_i;
   logic                  flush;

   // execute side
   logic                  m_valid;
   logic                  m_ready;
   ctrl_t                 ex_ctrl_o;
   logic [XLEN-1:0]       ex_rd1_o;
   logic [XLEN-1:0]       ex_rd2_o;
   logic [XLEN-1:0]       ex_imm_o;
   logic [XLEN-1:0]       ex_pc_o;
   logic [XLEN-1:0]       ex_pcplus4_o;
   logic [REG_ADDR_W-1:0] ex_rs1_o;
   logic [REG_ADDR_W-1:0] ex_rs2_o;
   logic [REG_ADDR_W-1:0] ex_rd_o;

   modport slave (
      input  s_valid, id_ctrl_i, id_rd1_i, id_rd2_i, id_imm_i, id_pc_i, id_pcplus4_i,
             id_rs1_i, id_rs2_i, id_rd_i, flush, m_ready,
      output s_ready, m_valid, ex_ctrl_o, ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc_o,
             ex_pcplus4_o, ex_rs1_o, ex_rs2_o, ex_rd_o
   );

   modport master (
      output s_valid, id_ctrl_i, id_rd1_i, id_rd2_i, id_imm_i, id_pc_i, id_pcplus4_i,
             id_rs1_i, id_rs2_i, id_rd_i, flush, m_ready,
      input  s_ready, m_valid, ex_ctrl_o, ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc_o,
             ex_pcplus4_o, ex_rs1_o, ex_rs2_o, ex_rd_o
   );

endinterface

// File: rtl/pipe_payload_reg.sv
// Width-agnostic enable-loaded payload register, cleared by reset.
// Latency: 1 cycle from load to q.
// Backpressure: none; holds q whenever load is low.
module pipe_payload_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // capture d on load, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/id_ex_skid_reg.sv
// Elastic ID/EX pipeline register with one-entry skid buffer and synchronous flush.
// Latency: 1 cycle accept-to-m_valid; full throughput while m_ready=1.
// Backpressure: registered s_ready drops only when skid is full; optional ID_EX_PERF_EN adds stall/bubble counters.
module id_ex_skid_reg
   import id_ex_skid_reg_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   id_ex_skid_reg_if.slave    bus
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]        stall_cnt_o,
   output logic [31:0]        bubble_cnt_o
`endif
);

   localparam int PAY_W = CTRL_W + 5 * XLEN + 3 * REG_ADDR_W;

   skid_state_e      state_q;
   skid_state_e      state_nxt;
   logic             s_ready_q;
   logic             main_v;
   logic             accept;
   logic             consume;
   logic             load_main;
   logic             load_skid;
   logic             sel_skid;
   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] main_d;
   logic [PAY_W-1:0] main_q;
   logic [PAY_W-1:0] skid_q;
   ctrl_t            main_ctrl;

   assign main_v  = state_q[1];
   assign accept  = bus.s_valid & s_ready_q;
   assign consume = main_v & bus.m_ready;

   assign in_pay = {bus.id_ctrl_i, bus.id_rd1_i, bus.id_rd2_i, bus.id_imm_i, bus.id_pc_i,
                    bus.id_pcplus4_i, bus.id_rs1_i, bus.id_rs2_i, bus.id_rd_i};

   // main refills from skid when draining FULL, otherwise straight from decode
   assign main_d = sel_skid ? skid_q : in_pay;

   pipe_payload_reg #(.W(PAY_W)) u_main (
      .clk  (clk),
      .rst  (rst),
      .load (load_main),
      .d    (main_d),
      .q    (main_q)
   );

   pipe_payload_reg #(.W(PAY_W)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (load_skid),
      .d    (in_pay),
      .q    (skid_q)
   );

   // occupancy state and registered ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_EMPTY;
         s_ready_q <= 1'b1;
      end else begin
         state_q   <= state_nxt;
         s_ready_q <= (state_nxt != ST_FULL);
      end
   end

   // next occupancy and payload load strobes; flush wins over everything
   always_comb begin
      state_nxt = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      sel_skid  = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               load_main = 1'b1;
               state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && consume) begin
               load_main = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_nxt = ST_FULL;
            end else if (consume) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // s_ready is low here, so nothing new can arrive
            if (consume) begin
               load_main = 1'b1;
               sel_skid  = 1'b1;
               state_nxt = ST_ONE;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
      if (bus.flush) begin
         state_nxt = ST_EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
         sel_skid  = 1'b0;
      end
   end

   assign {main_ctrl, bus.ex_rd1_o, bus.ex_rd2_o, bus.ex_imm_o, bus.ex_pc_o,
           bus.ex_pcplus4_o, bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_rd_o} = main_q;

   // ctrl reads as a NOP whenever main is empty so execute cannot act on stale data
   assign bus.ex_ctrl_o = main_v ? main_ctrl : CTRL_NOP;
   assign bus.s_ready   = s_ready_q;
   assign bus.m_valid   = main_v;

`ifdef ID_EX_PERF_EN
   // saturating stall/bubble counters, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_o  <= '0;
         bubble_cnt_o <= '0;
      end else begin
         if (main_v && !bus.m_ready) begin
            stall_cnt_o <= sat_inc(stall_cnt_o);
         end
         if (!main_v && bus.m_ready) begin
            bubble_cnt_o <= sat_inc(bubble_cnt_o);
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: directed scenarios plus random traffic checked against a 2-deep FIFO model.
// Latency: model predicts one-cycle accept-to-output.
// Backpressure: random m_ready stalls and flushes; counters checked when ID_EX_PERF_EN is defined.
module tb_id_ex_skid_reg;
   import id_ex_skid_reg_pkg::*;

   typedef struct packed {
      ctrl_t       ctrl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pcplus4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } pay_t;

   logic clk;
   logic rst;
   id_ex_skid_reg_if bus ();

`ifdef ID_EX_PERF_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] bubble_cnt_o;
`endif

   id_ex_skid_reg dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus)
`ifdef ID_EX_PERF_EN
      ,
      .stall_cnt_o  (stall_cnt_o),
      .bubble_cnt_o (bubble_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int unsigned seq = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: ordered queue of at most two instructions
   pay_t        exp_q[$];
   logic [31:0] m_stall;
   logic [31:0] m_bubble;
   bit          m_vld;
   bit          m_rdy;

   function automatic pay_t in_payload();
      return {bus.id_ctrl_i, bus.id_rd1_i, bus.id_rd2_i, bus.id_imm_i, bus.id_pc_i,
              bus.id_pcplus4_i, bus.id_rs1_i, bus.id_rs2_i, bus.id_rd_i};
   endfunction

   function automatic pay_t out_payload();
      return {bus.ex_ctrl_o, bus.ex_rd1_o, bus.ex_rd2_o, bus.ex_imm_o, bus.ex_pc_o,
              bus.ex_pcplus4_o, bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_rd_o};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_stall  = '0;
         m_bubble = '0;
      end else begin
         m_vld = (exp_q.size() > 0);
         m_rdy = (exp_q.size() < 2);
         if (m_vld && !bus.m_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (!m_vld && bus.m_ready && m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 1;
         if (bus.flush) begin
            exp_q.delete();
         end else begin
            if (m_vld && bus.m_ready) void'(exp_q.pop_front());
            if (bus.s_valid && m_rdy) exp_q.push_back(in_payload());
         end
      end
   end

   // ---------------- monitor: compare DUT outputs with the model mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         chk("s_ready", bus.s_ready, exp_q.size() < 2);
         chk("m_valid", bus.m_valid, exp_q.size() > 0);
         if (exp_q.size() > 0) begin
            chk("payload", out_payload(), exp_q[0]);
         end else begin
            chk("bubble_ctrl", bus.ex_ctrl_o, 10'd0);
         end
`ifdef ID_EX_PERF_EN
         chk("stall_cnt", stall_cnt_o, m_stall);
         chk("bubble_cnt", bubble_cnt_o, m_bubble);
`endif
      end
   end

   // ---------------- stimulus
   task automatic drive(input bit sv, input bit mr, input bit fl, input logic [2:0] alu);
      bus.s_valid               = sv;
      bus.m_ready               = mr;
      bus.flush                 = fl;
      bus.id_ctrl_i             = CTRL_W'($urandom);
      bus.id_ctrl_i.alu_control = alu;
      bus.id_rd1_i              = $urandom;
      bus.id_rd2_i              = $urandom;
      bus.id_imm_i              = $urandom;
      bus.id_pc_i               = seq * 4;
      bus.id_pcplus4_i          = seq * 4 + 4;
      bus.id_rs1_i              = 5'($urandom);
      bus.id_rs2_i              = 5'($urandom);
      bus.id_rd_i               = 5'($urandom);
      seq++;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_m_valid"}, bus.m_valid, 1'b0);
      chk({tag, "_s_ready"}, bus.s_ready, 1'b1);
      chk({tag, "_ex_ctrl"}, bus.ex_ctrl_o, 10'd0);
      chk({tag, "_ex_all"}, out_payload(), '0);
`ifdef ID_EX_PERF_EN
      chk({tag, "_stall_cnt"}, stall_cnt_o, 32'd0);
      chk({tag, "_bubble_cnt"}, bubble_cnt_o, 32'd0);
`endif
   endtask

   logic [2:0] alu_seq [8];

   initial begin
      alu_seq = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000, 3'b001};
      rst         = 1'b1;
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b0;
      bus.flush   = 1'b0;
      bus.id_ctrl_i = '0;
      bus.id_rd1_i = '0; bus.id_rd2_i = '0; bus.id_imm_i = '0;
      bus.id_pc_i = '0; bus.id_pcplus4_i = '0;
      bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_rd_i = '0;
      #2;
      check_reset_outputs("por");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

`ifdef ID_EX_PERF_EN
      // 2 idle m_ready cycles, 1 neutral fill, 3 stalls, flush during consume
      drive(0, 1, 0, 3'd0);
      drive(0, 1, 0, 3'd0);
      drive(1, 0, 0, 3'd0);
      drive(0, 0, 0, 3'd0);
      drive(0, 0, 0, 3'd0);
      drive(0, 0, 0, 3'd0);
      drive(0, 1, 1, 3'd0);
      drive(0, 0, 0, 3'd0);
      chk("perf_stall_3", stall_cnt_o, 32'd3);
      chk("perf_bubble_2", bubble_cnt_o, 32'd2);
`endif

      // streaming: 8 back-to-back with m_ready held high
      for (int i = 0; i < 8; i++) drive(1, 1, 0, alu_seq[i]);
      drive(0, 1, 0, 3'd0);
      drive(0, 1, 0, 3'd0);
      chk("stream_drained", bus.m_valid, 1'b0);

      // backpressure: 4 stall cycles with decode pushing
      for (int i = 0; i < 4; i++) drive(1, 0, 0, ALU_SUB);
      chk("bp_s_ready_low", bus.s_ready, 1'b0);
      chk("bp_m_valid_high", bus.m_valid, 1'b1);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 3'd0);
      chk("bp_drained", bus.m_valid, 1'b0);

      // flush in FULL with an incoming instruction
      drive(1, 0, 0, ALU_AND);
      drive(1, 0, 0, ALU_OR);
      chk("pre_flush_full", bus.s_ready, 1'b0);
      drive(1, 0, 1, ALU_SLT);
      chk("flush_m_valid", bus.m_valid, 1'b0);
      chk("flush_ex_ctrl", bus.ex_ctrl_o, 10'd0);
      chk("flush_s_ready", bus.s_ready, 1'b1);

      // flush together with accept and consume while in ONE
      drive(1, 0, 0, ALU_ADD);
      drive(1, 1, 1, ALU_SUB);
      chk("comb_flush_empty", bus.m_valid, 1'b0);
      chk("comb_flush_s_ready", bus.s_ready, 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, 3'($urandom));
      end

      // asynchronous reset mid-stream
      drive(1, 0, 0, ALU_OR);
      drive(1, 0, 0, ALU_AND);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      bus.s_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         drive(($urandom % 2) != 0, ($urandom % 2) != 0, 1'b0, 3'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_ex_skid_reg.md
# id_ex_skid_reg

Elastic decode-to-execute pipeline register for the RISC-V pipeline. It captures the decoded control bundle (including the 3-bit ALU control code from the ALU decoder), register-file read data, immediate and PC values, and presents them to the execute stage. A valid/ready handshake and a one-entry skid buffer let execute stall without a combinational ready path back into decode. A synchronous flush squashes in-flight instructions on branch or jump redirects.

## Interface
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  decode presents a valid instruction
- s_ready  out  1  register can accept; registered output
- id_ctrl_i  in  10  {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
- id_rd1_i, id_rd2_i, id_imm_i, id_pc_i, id_pcplus4_i  in  XLEN each  operand, immediate and PC payload
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_ADDR_W each  register indices
- flush  in  1  squash all held entries
- m_valid  out  1  execute-side payload valid
- m_ready  in  1  execute consumes this cycle
- ex_ctrl_o, ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc_o, ex_pcplus4_o, ex_rs1_o, ex_rs2_o, ex_rd_o  out  same widths as the inputs  execute-side payload
- stall_cnt_o, bubble_cnt_o  out  32 each  present only when the macro is defined

## Operation
- Storage:
  - main entry (main_v, main_payload) drives the ex_* outputs.
  - skid entry (skid_v, skid_payload) holds one overflow instruction.
- Handshakes:
  - Accept = s_valid & s_ready.
  - Consume = m_valid & m_ready.
  - m_valid = main_v.
- States, encoded by {main_v, skid_v}:
  - EMPTY (00)
  - ONE (10)
  - FULL (11)
  - 01 is illegal and must never occur.
- EMPTY:
  - Accept: load main, go to ONE.
- ONE:
  - Accept with consume: load main, stay ONE.
  - Accept without consume: load skid, go to FULL.
  - Consume without accept: go to EMPTY.
- FULL (s_ready=0):
  - Consume: move skid to main, go to ONE.
- s_ready is registered:
  - Next value is 0 exactly when the next state is FULL, otherwise 1.
  - There is no combinational path from m_ready to s_ready.
- Flush:
  - Synchronous; next state is EMPTY.
  - Overrides any accept or consume in the same cycle; the incoming instruction is dropped.
  - Next-cycle s_ready = 1.
- Bubble semantics:
  - Whenever main_v is 0, ex_ctrl_o reads all-zero (RegWrite=0, MemWrite=0, Jump=0, Branch=0).
  - Execute stays safe even if it ignores m_valid.
  - Payload fields other than ctrl keep their last value.
- Ordering is strict FIFO. No field is modified in transit.

## Timing
- Reset (async assert):
  - main_v=0, skid_v=0, s_ready=1, m_valid=0.
  - All ex_* outputs and both counters are 0.
  - Release is synchronous to clk.
- Latency: an instruction accepted at edge N appears on ex_* with m_valid=1 after edge N (one cycle).
- Throughput: one instruction per cycle while m_ready=1.
- Stall of k cycles: at most one extra instruction is absorbed. s_ready drops the cycle after skid fills.
- Reset mid-operation discards all entries. No partial payload reaches ex_* after reset.

## Configuration
- ID_EX_PERF_EN defined:
  - stall_cnt_o increments every cycle with m_valid & !m_ready.
  - bubble_cnt_o increments every cycle with !m_valid & m_ready.
  - Both are 32-bit, saturate at all-ones, and are cleared only by rst (not by flush).
- ID_EX_PERF_EN undefined: the counters and ports are absent. Handshake behaviour is identical.

## Structure
- The shared pipeline package holds:
  - the ctrl bundle typedef and its field offsets;
  - CTRL_W=10;
  - the ALUControl encodings (ADD=000, SUB=001, AND=010, OR=011, SLT=101);
  - the zero bubble constant CTRL_NOP.
- One sub-module, pipe_payload_reg: an XLEN-agnostic enable-loaded payload register. It is instantiated twice, once for main and once for skid.
- The FSM and handshake logic stay in id_ex_skid_reg.

## Test plan
- Reset check: assert rst mid-stream. Required: m_valid=0, s_ready=1, ex_ctrl_o=0 immediately, without waiting for a clock edge.
- Streaming: send 8 back-to-back instructions with ALUControl 000..101 and m_ready=1. Required: each appears one cycle later, in order, m_valid continuous.
- Backpressure:
  - Stimulus: m_ready=0 for 4 cycles while s_valid=1.
  - Required: exactly 2 instructions held; s_ready=0 from the 3rd cycle.
  - After release, both instructions drain in order with no loss or duplication.
- Flush: assert flush in FULL state with s_valid=1. Required: next cycle m_valid=0, ex_ctrl_o=0, s_ready=1, and the incoming instruction is dropped.
- Combined flush: flush asserted together with consume and accept in ONE. Required: EMPTY next cycle.
- ID_EX_PERF_EN counters: 3 stall cycles and 2 idle m_ready cycles. Required: stall_cnt_o=3, bubble_cnt_o=2. Flush leaves both unchanged.
